// File: rtl/sd_route_act.sv
// rtl/sd_route_act.sv - SD SPI router: physical card or one of NCH virtual channels, with mount and activity tracking
// Optional feature macro: SD_ROUTE_BLINK_EN (blinking activity LED).
module sd_route_act #(
  parameter int NCH     = 2,
  parameter int CW      = 1,
  parameter int TIMEOUT = 1000000,
  parameter int TW      = 20
`ifdef SD_ROUTE_BLINK_EN
  , parameter int BLINK_SH = 22
`endif
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic [NCH-1:0] img_mounted,
  input  logic [NCH-1:0] img_nz,
  input  logic [CW-1:0]  drive_sel,
  input  logic           spi_sck,
  input  logic           spi_ss,
  input  logic           spi_mosi,
  output logic           spi_miso,
  output logic           sd_sck,
  output logic           sd_cs,
  output logic           sd_mosi,
  input  logic           sd_miso,
  output logic [NCH-1:0] vsd_ss,
  input  logic [NCH-1:0] vsd_miso,
  output logic [NCH-1:0] mounted,
  output logic [NCH:0]   act,
  output logic           led
);

  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  logic          rvirt;
  logic [CW-1:0] rch;
  logic          sel_mounted;
  logic [NCH:0]  route_hot;
  logic          mosi_q;
  logic          miso_q;
  logic          edge_det;
  logic [TW-1:0] cnt      [NCH+1];
  logic [TW-1:0] cnt_next [NCH+1];
  logic [NCH:0]  act_next;

  // Out-of-range drive_sel matches no channel, so it falls through to the physical card.
  always_comb begin
    sel_mounted = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (drive_sel == CW'(i)) sel_mounted = mounted[i];
    end
  end

  always_comb begin
    vsd_ss   = '1;
    sd_cs    = 1'b1;
    sd_sck   = 1'b0;
    sd_mosi  = 1'b0;
    spi_miso = sd_miso;
    if (rvirt) begin
      for (int i = 0; i < NCH; i++) begin
        if (rch == CW'(i)) begin
          vsd_ss[i] = spi_ss;
          spi_miso  = vsd_miso[i];
        end
      end
    end else begin
      sd_cs    = spi_ss;
      sd_sck   = spi_sck;
      sd_mosi  = spi_mosi;
      spi_miso = sd_miso;
    end
  end

  always_comb begin
    route_hot = '0;
    if (rvirt) begin
      for (int i = 0; i < NCH; i++) begin
        if (rch == CW'(i)) route_hot[i] = 1'b1;
      end
    end else begin
      route_hot[NCH] = 1'b1;
    end
  end

  assign edge_det = (spi_mosi ^ mosi_q) | (spi_miso ^ miso_q);

  // A fresh edge beats the counter saturating on the same cycle.
  always_comb begin
    for (int k = 0; k <= NCH; k++) begin
      if (edge_det && route_hot[k]) begin
        cnt_next[k] = '0;
      end else if (cnt[k] < TMO) begin
        cnt_next[k] = cnt[k] + TW'(1);
      end else begin
        cnt_next[k] = cnt[k];
      end
      act_next[k] = (cnt_next[k] < TMO);
    end
  end

`ifdef SD_ROUTE_BLINK_EN
  logic [BLINK_SH-1:0] blink;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      blink <= '0;
      led   <= 1'b0;
    end else begin
      blink <= blink + BLINK_SH'(1);
      led   <= (|act_next[NCH-1:0]) & blink[BLINK_SH-1];
    end
  end
`else
  always_ff @(posedge clk_sys) begin
    if (reset) led <= 1'b0;
    else       led <= |act_next[NCH-1:0];
  end
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mounted <= '0;
      rvirt   <= 1'b0;
      rch     <= '0;
      mosi_q  <= 1'b0;
      miso_q  <= 1'b0;
      act     <= '0;
      for (int k = 0; k <= NCH; k++) cnt[k] <= TMO;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (img_mounted[i]) mounted[i] <= img_nz[i];
      end
      // Route only moves between transfers; mid-transfer changes wait for ss high.
      if (spi_ss) begin
        rch   <= drive_sel;
        rvirt <= sel_mounted;
      end
      mosi_q <= spi_mosi;
      miso_q <= spi_miso;
      act    <= act_next;
      for (int k = 0; k <= NCH; k++) cnt[k] <= cnt_next[k];
    end
  end

endmodule

// File: tb/tb_sd_route_act.sv
// tb/tb_sd_route_act.sv - randomized self-checking bench for sd_route_act against a last-edge-time model
module tb_sd_route_act;

  localparam int NCH = 2;
  localparam int CW = 2;
  localparam int TIMEOUT = 16;
  localparam int TW = 5;

  logic           clk_sys = 1'b0;
  logic           reset;
  logic [NCH-1:0] img_mounted, img_nz, vsd_ss, vsd_miso, mounted;
  logic [CW-1:0]  drive_sel;
  logic           spi_sck, spi_ss, spi_mosi, spi_miso;
  logic           sd_sck, sd_cs, sd_mosi, sd_miso, led;
  logic [NCH:0]   act;

  int checks = 0;
  int errors = 0;

  // Reference state: mount bits, route, and the cycle of the most recent edge per entry.
  logic [NCH-1:0] m_mounted;
  logic           m_virt;
  int             m_ch;
  int             last_edge [NCH+1];
  int             cyc = 0;
  int             now_cyc = 0;
  logic           p_mosi, p_miso;

  always #5 clk_sys = ~clk_sys;

  sd_route_act #(.NCH(NCH), .CW(CW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_nz(img_nz),
    .drive_sel(drive_sel), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .sd_sck(sd_sck), .sd_cs(sd_cs), .sd_mosi(sd_mosi),
    .sd_miso(sd_miso), .vsd_ss(vsd_ss), .vsd_miso(vsd_miso), .mounted(mounted),
    .act(act), .led(led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: observed %0h expected %0h", tag, now_cyc, obs, exp);
    end
  endtask

  task automatic model_tick();
    logic m_miso, e;
    if (reset) begin
      m_mounted = '0;
      m_virt = 1'b0;
      m_ch = 0;
      p_mosi = 1'b0;
      p_miso = 1'b0;
      for (int k = 0; k <= NCH; k++) last_edge[k] = -100000;
    end else begin
      m_miso = m_virt ? vsd_miso[m_ch] : sd_miso;
      e = (spi_mosi != p_mosi) || (m_miso != p_miso);
      if (e) last_edge[m_virt ? m_ch : NCH] = cyc;
      p_mosi = spi_mosi;
      p_miso = m_miso;
      if (spi_ss) begin
        m_ch = int'(drive_sel);
        m_virt = (m_ch < NCH) ? m_mounted[m_ch] : 1'b0;
      end
      for (int i = 0; i < NCH; i++) if (img_mounted[i]) m_mounted[i] = img_nz[i];
    end
    now_cyc = cyc;
    cyc++;
  endtask

  task automatic check_outputs();
    logic [NCH:0]   e_act;
    logic [NCH-1:0] e_vss;
    for (int k = 0; k <= NCH; k++) e_act[k] = (now_cyc - last_edge[k]) < TIMEOUT;
    for (int i = 0; i < NCH; i++) e_vss[i] = (m_virt && m_ch == i) ? spi_ss : 1'b1;
    check("mounted", 32'(mounted), 32'(m_mounted));
    check("act", 32'(act), 32'(e_act));
    check("led", 32'(led), 32'(|e_act[NCH-1:0]));
    check("vsd_ss", 32'(vsd_ss), 32'(e_vss));
    check("sd_cs", 32'(sd_cs), 32'(m_virt ? 1'b1 : spi_ss));
    check("sd_sck", 32'(sd_sck), 32'(m_virt ? 1'b0 : spi_sck));
    check("sd_mosi", 32'(sd_mosi), 32'(m_virt ? 1'b0 : spi_mosi));
    check("spi_miso", 32'(spi_miso), 32'(m_virt ? vsd_miso[m_ch] : sd_miso));
  endtask

  task automatic step(input int n = 1);
    for (int j = 0; j < n; j++) begin
      @(posedge clk_sys);
      model_tick();
      @(negedge clk_sys);
      check_outputs();
      img_mounted = '0;
    end
  endtask

  initial begin
    reset = 1'b1; img_mounted = '0; img_nz = '0; drive_sel = '0;
    spi_sck = 1'b0; spi_ss = 1'b1; spi_mosi = 1'b0; sd_miso = 1'b0; vsd_miso = '0;
    step(2);
    reset = 1'b0;
    step(1);
    check("reset_sd_cs", 32'(sd_cs), 32'd1);
    check("reset_vsd_ss", 32'(vsd_ss), 32'b11);
    sd_miso = 1'b1;
    step(1);

    // Mount channel 0 and switch to it.
    img_mounted = 2'b01; img_nz = 2'b01; drive_sel = 2'd0;
    step(1);
    check("mount0", 32'(mounted), 32'b01);
    step(1);
    spi_ss = 1'b0;
    step(1);
    check("virt_vsd_ss", 32'(vsd_ss), 32'b10);
    check("virt_sd_cs", 32'(sd_cs), 32'd1);

    // Activity timeout, then a re-toggle exactly on the timeout cycle.
    spi_mosi = 1'b1;
    step(1);
    check("act0_rise", 32'(act[0]), 32'd1);
    step(15);
    check("act0_hold", 32'(act[0]), 32'd1);
    step(1);
    check("act0_fall", 32'(act[0]), 32'd0);
    spi_mosi = 1'b0;
    step(16);
    spi_mosi = 1'b1;
    step(1);
    check("act0_retrig", 32'(act[0]), 32'd1);

    // Deferred route change while ss is low on the physical route.
    spi_ss = 1'b1; drive_sel = 2'd1;
    step(2);
    spi_ss = 1'b0; drive_sel = 2'd0; img_mounted = 2'b10; img_nz = 2'b10;
    step(3);
    check("defer_phys", 32'(sd_cs), 32'd0);
    spi_ss = 1'b1;
    step(1);
    spi_ss = 1'b0;
    step(1);
    check("defer_virt", 32'(vsd_ss), 32'b10);

    // Out-of-range drive_sel forces physical; edges land on act[2] only.
    spi_ss = 1'b1; drive_sel = 2'd3;
    step(1);
    spi_ss = 1'b0;
    step(20);
    spi_mosi = ~spi_mosi;
    step(1);
    check("oor_act", 32'(act), 32'b100);
    check("oor_led", 32'(led), 32'd0);

    // Unmount channel 0.
    spi_ss = 1'b1; drive_sel = 2'd0;
    step(2);
    img_mounted = 2'b01; img_nz = 2'b00;
    step(2);
    spi_ss = 1'b0;
    step(1);
    check("unmount_phys", 32'(sd_cs), 32'd0);

    // Random phase.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      img_mounted = ($urandom_range(0, 19) == 0) ? NCH'($urandom) : '0;
      img_nz = NCH'($urandom);
      if ($urandom_range(0, 7) == 0) drive_sel = CW'($urandom);
      if ($urandom_range(0, 5) == 0) spi_ss = ~spi_ss;
      spi_sck = 1'($urandom);
      if ($urandom_range(0, 24) == 0) spi_mosi = ~spi_mosi;
      if ($urandom_range(0, 29) == 0) sd_miso = ~sd_miso;
      if ($urandom_range(0, 29) == 0) vsd_miso = NCH'($urandom);
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
